// File: rtl/soft_error_pkg.sv
// Shared definitions for the soft-error monitor: default counter width and health encodings.
// Latency: none (package only).
// Backpressure: none (package only).
package soft_error_pkg;

  localparam int CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    HEALTH_OK    = 2'd0,
    HEALTH_WARN  = 2'd1,
    HEALTH_ERROR = 2'd2
  } health_t;

endpackage

// File: rtl/soft_err_channel.sv
// One soft-error channel: saturating event counter, threshold compare and sticky error flag.
// Latency: event -> count 1 cycle; count reaching threshold -> flag 1 further cycle.
// Backpressure: none; one event per cycle is always accepted, counter saturates instead of wrapping.
//
// Ports:
//   clk, reset_n        clock and asynchronous active-low reset
//   hit                 one-cycle event pulse
//   thr                 trip threshold, 0 disables the flag and the warning
//   clear_counts        zeroes the counter (a same-cycle hit still counts as 1)
//   clear_errors        clears the sticky flag (wins over a same-cycle trip)
//   count               registered saturating event count
//   flag                registered sticky error flag
//   warn                count has reached half the threshold (decoded from registered count)
module soft_err_channel #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hit,
  input  logic [CNT_W-1:0] thr,
  input  logic             clear_counts,
  input  logic             clear_errors,
  output logic [CNT_W-1:0] count,
  output logic             flag,
  output logic             warn
);

  logic trip;

  // Compare uses the registered count, so the flag lands one cycle after the count.
  assign trip = (thr != '0) && (count >= thr);
  assign warn = (thr != '0) && (count >= (thr >> 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear_counts) begin
      // A hit coinciding with the clear is the first event of the new epoch.
      count <= hit ? CNT_W'(1) : '0;
    end else if (hit && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flag <= 1'b0;
    end else if (clear_errors) begin
      // Clear wins for this cycle; a persisting trip re-sets the flag next cycle.
      flag <= 1'b0;
    end else if (trip) begin
      flag <= 1'b1;
    end
  end

endmodule

// File: rtl/soft_error_monitor.sv
// Counts checksum, unknown-TTC and DDR3-overflow events, raises sticky errors and an aggregate health state.
// Latency: event -> count 1 cycle, -> flag 2 cycles, -> health ERROR 3 cycles; all outputs registered.
// Backpressure: none; events are pulses accepted every cycle, counters saturate.
//
// Ports:
//   clk, reset_n                        clock and asynchronous active-low reset
//   cs_mismatch/unknown_cmd/ddr3_overflow  one-cycle event pulses
//   thres_*                             per-channel thresholds, 0 disables that error
//   clear_counts, clear_errors          IPbus clear pulses
//   *_count                             saturating per-source counts
//   error_*                             sticky per-source error flags
//   health                              0 OK, 1 WARN, 2 ERROR
module soft_error_monitor
  import soft_error_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cs_mismatch,
  input  logic             unknown_cmd,
  input  logic             ddr3_overflow,
  input  logic [CNT_W-1:0] thres_data_corrupt,
  input  logic [CNT_W-1:0] thres_unknown_ttc,
  input  logic [CNT_W-1:0] thres_ddr3_overflow,
  input  logic             clear_counts,
  input  logic             clear_errors,
  output logic [CNT_W-1:0] cs_mismatch_count,
  output logic [CNT_W-1:0] unknown_cmd_count,
  output logic [CNT_W-1:0] ddr3_overflow_count,
  output logic             error_data_corrupt,
  output logic             error_unknown_ttc,
  output logic             error_ddr3_overflow,
  output logic [1:0]       health
);

  logic    warn_dc, warn_ut, warn_dd;
  logic    any_flag, any_warn;
  health_t state;

  soft_err_channel #(.CNT_W(CNT_W)) u_ch_data_corrupt (
    .clk          (clk),
    .reset_n      (reset_n),
    .hit          (cs_mismatch),
    .thr          (thres_data_corrupt),
    .clear_counts (clear_counts),
    .clear_errors (clear_errors),
    .count        (cs_mismatch_count),
    .flag         (error_data_corrupt),
    .warn         (warn_dc)
  );

  soft_err_channel #(.CNT_W(CNT_W)) u_ch_unknown_ttc (
    .clk          (clk),
    .reset_n      (reset_n),
    .hit          (unknown_cmd),
    .thr          (thres_unknown_ttc),
    .clear_counts (clear_counts),
    .clear_errors (clear_errors),
    .count        (unknown_cmd_count),
    .flag         (error_unknown_ttc),
    .warn         (warn_ut)
  );

  soft_err_channel #(.CNT_W(CNT_W)) u_ch_ddr3_overflow (
    .clk          (clk),
    .reset_n      (reset_n),
    .hit          (ddr3_overflow),
    .thr          (thres_ddr3_overflow),
    .clear_counts (clear_counts),
    .clear_errors (clear_errors),
    .count        (ddr3_overflow_count),
    .flag         (error_ddr3_overflow),
    .warn         (warn_dd)
  );

  assign any_flag = error_data_corrupt | error_unknown_ttc | error_ddr3_overflow;
  assign any_warn = warn_dc | warn_ut | warn_dd;

  // Health follows the registered flags, so ERROR trails the flag by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= HEALTH_OK;
    end else begin
      case (state)
        HEALTH_OK: begin
          if (any_flag)      state <= HEALTH_ERROR;
          else if (any_warn) state <= HEALTH_WARN;
        end
        HEALTH_WARN: begin
          if (any_flag)       state <= HEALTH_ERROR;
          else if (!any_warn) state <= HEALTH_OK;
        end
        HEALTH_ERROR: begin
          if (!any_flag) state <= any_warn ? HEALTH_WARN : HEALTH_OK;
        end
        default: state <= HEALTH_OK;
      endcase
    end
  end

  assign health = state;

endmodule

// File: tb/tb_soft_error_monitor.sv
// Directed, table-driven bench for soft_error_monitor, plus hand sequences for corner cases.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_soft_error_monitor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs_mismatch, unknown_cmd, ddr3_overflow;
  logic [31:0] thres_data_corrupt, thres_unknown_ttc, thres_ddr3_overflow;
  logic        clear_counts, clear_errors;
  logic [31:0] cs_mismatch_count, unknown_cmd_count, ddr3_overflow_count;
  logic        error_data_corrupt, error_unknown_ttc, error_ddr3_overflow;
  logic [1:0]  health;

  // Narrow instance used to reach saturation in a few cycles.
  logic        s_cs, s_uc, s_dd;
  logic [3:0]  s_thr_dc, s_thr_ut, s_thr_dd;
  logic        s_cc, s_ce;
  logic [3:0]  s_cnt_cs, s_cnt_uc, s_cnt_dd;
  logic        s_err_dc, s_err_ut, s_err_dd;
  logic [1:0]  s_health;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soft_error_monitor #(.CNT_W(32)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cs_mismatch         (cs_mismatch),
    .unknown_cmd         (unknown_cmd),
    .ddr3_overflow       (ddr3_overflow),
    .thres_data_corrupt  (thres_data_corrupt),
    .thres_unknown_ttc   (thres_unknown_ttc),
    .thres_ddr3_overflow (thres_ddr3_overflow),
    .clear_counts        (clear_counts),
    .clear_errors        (clear_errors),
    .cs_mismatch_count   (cs_mismatch_count),
    .unknown_cmd_count   (unknown_cmd_count),
    .ddr3_overflow_count (ddr3_overflow_count),
    .error_data_corrupt  (error_data_corrupt),
    .error_unknown_ttc   (error_unknown_ttc),
    .error_ddr3_overflow (error_ddr3_overflow),
    .health              (health)
  );

  soft_error_monitor #(.CNT_W(4)) dut_small (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cs_mismatch         (s_cs),
    .unknown_cmd         (s_uc),
    .ddr3_overflow       (s_dd),
    .thres_data_corrupt  (s_thr_dc),
    .thres_unknown_ttc   (s_thr_ut),
    .thres_ddr3_overflow (s_thr_dd),
    .clear_counts        (s_cc),
    .clear_errors        (s_ce),
    .cs_mismatch_count   (s_cnt_cs),
    .unknown_cmd_count   (s_cnt_uc),
    .ddr3_overflow_count (s_cnt_dd),
    .error_data_corrupt  (s_err_dc),
    .error_unknown_ttc   (s_err_ut),
    .error_ddr3_overflow (s_err_dd),
    .health              (s_health)
  );

  typedef struct {
    logic        cs, uc, dd, cc, ce;
    logic [31:0] ea, eb, ec;
    logic [2:0]  ef;   // {data_corrupt, unknown_ttc, ddr3_overflow}
    logic [1:0]  eh;
  } vec_t;

  vec_t tbl [22];

  function automatic vec_t mk(input logic cs, uc, dd, cc, ce,
                              input logic [31:0] ea, eb, ec,
                              input logic [2:0] ef, input logic [1:0] eh);
    vec_t v;
    v.cs = cs; v.uc = uc; v.dd = dd; v.cc = cc; v.ce = ce;
    v.ea = ea; v.eb = eb; v.ec = ec; v.ef = ef; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; outputs are sampled 1 unit after the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cs_mismatch = 0; unknown_cmd = 0; ddr3_overflow = 0;
    clear_counts = 0; clear_errors = 0;
    s_cs = 0; s_uc = 0; s_dd = 0; s_cc = 0; s_ce = 0;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] ea, eb, ec,
                         input logic [2:0] ef, input logic [1:0] eh);
    chk({tag, "_cs_count"},   cs_mismatch_count,   ea);
    chk({tag, "_uc_count"},   unknown_cmd_count,   eb);
    chk({tag, "_dd_count"},   ddr3_overflow_count, ec);
    chk({tag, "_flags"},      {29'd0, error_data_corrupt, error_unknown_ttc, error_ddr3_overflow}, {29'd0, ef});
    chk({tag, "_health"},     {30'd0, health}, {30'd0, eh});
  endtask

  initial begin
    // Thresholds: data_corrupt 4 (warn at 2), unknown_ttc disabled, ddr3 10 (warn at 5).
    tbl[0]  = mk(1,0,0,0,0, 1,0,0, 3'b000, 0);
    tbl[1]  = mk(1,0,0,0,0, 2,0,0, 3'b000, 0);
    tbl[2]  = mk(1,0,0,0,0, 3,0,0, 3'b000, 1);
    tbl[3]  = mk(1,0,0,0,0, 4,0,0, 3'b000, 1);
    tbl[4]  = mk(0,0,0,0,0, 4,0,0, 3'b100, 1);
    tbl[5]  = mk(0,0,0,0,0, 4,0,0, 3'b100, 2);
    tbl[6]  = mk(0,0,0,0,1, 4,0,0, 3'b000, 2);
    tbl[7]  = mk(0,0,0,0,0, 4,0,0, 3'b100, 1);
    tbl[8]  = mk(0,0,0,0,0, 4,0,0, 3'b100, 2);
    tbl[9]  = mk(0,0,0,1,0, 0,0,0, 3'b100, 2);
    tbl[10] = mk(0,0,0,0,1, 0,0,0, 3'b000, 2);
    tbl[11] = mk(0,0,0,0,0, 0,0,0, 3'b000, 0);
    tbl[12] = mk(1,0,0,1,0, 1,0,0, 3'b000, 0);
    tbl[13] = mk(0,0,0,1,0, 0,0,0, 3'b000, 0);
    tbl[14] = mk(0,0,1,0,0, 0,0,1, 3'b000, 0);
    tbl[15] = mk(0,0,1,0,0, 0,0,2, 3'b000, 0);
    tbl[16] = mk(0,0,1,0,0, 0,0,3, 3'b000, 0);
    tbl[17] = mk(0,0,1,0,0, 0,0,4, 3'b000, 0);
    tbl[18] = mk(0,0,1,0,0, 0,0,5, 3'b000, 0);
    tbl[19] = mk(0,0,0,0,0, 0,0,5, 3'b000, 1);
    tbl[20] = mk(0,0,0,1,0, 0,0,0, 3'b000, 1);
    tbl[21] = mk(0,0,0,0,0, 0,0,0, 3'b000, 0);

    reset_n = 0;
    idle_inputs();
    thres_data_corrupt  = 32'd4;
    thres_unknown_ttc   = 32'd0;
    thres_ddr3_overflow = 32'd10;
    s_thr_dc = 4'd0; s_thr_ut = 4'd0; s_thr_dd = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;

    // Reset state after 10 idle cycles.
    repeat (10) tick();
    chk_all("reset_idle", 0, 0, 0, 3'b000, 0);

    // Main table: one vector per cycle.
    for (int i = 0; i < 22; i++) begin
      cs_mismatch   = tbl[i].cs;
      unknown_cmd   = tbl[i].uc;
      ddr3_overflow = tbl[i].dd;
      clear_counts  = tbl[i].cc;
      clear_errors  = tbl[i].ce;
      tick();
      chk_all($sformatf("v%0d", i), tbl[i].ea, tbl[i].eb, tbl[i].ec, tbl[i].ef, tbl[i].eh);
    end
    idle_inputs();

    // Disabled threshold: 100 unknown_cmd pulses never raise a flag or a warning.
    for (int i = 0; i < 100; i++) begin
      unknown_cmd = 1;
      tick();
      chk($sformatf("ut_dis_flag_%0d", i),   {31'd0, error_unknown_ttc}, 32'd0);
      chk($sformatf("ut_dis_health_%0d", i), {30'd0, health}, 32'd0);
    end
    unknown_cmd = 0;
    tick();
    chk("ut_count_100", unknown_cmd_count, 32'd100);

    // Lowering the threshold below the count trips on the next compare.
    thres_unknown_ttc = 32'd50;
    tick();
    chk("ut_thr_lower_flag",   {31'd0, error_unknown_ttc}, 32'd1);
    chk("ut_thr_lower_health", {30'd0, health}, 32'd1);
    tick();
    chk("ut_thr_lower_health2", {30'd0, health}, 32'd2);
    thres_unknown_ttc = 32'd0;
    clear_errors = 1;
    tick();
    chk("ut_clr_flag",   {31'd0, error_unknown_ttc}, 32'd0);
    chk("ut_clr_health", {30'd0, health}, 32'd2);
    clear_errors = 0;
    clear_counts = 1;
    tick();
    chk("ut_clr_health2", {30'd0, health}, 32'd0);
    chk("ut_clr_count",   unknown_cmd_count, 32'd0);
    chk("ut_clr_flag2",   {31'd0, error_unknown_ttc}, 32'd0);
    clear_counts = 0;

    // Saturation on the narrow instance: 14 pulses, then 3 more hold at the maximum.
    for (int i = 0; i < 14; i++) begin
      s_dd = 1;
      tick();
    end
    chk("sat_count_14", {28'd0, s_cnt_dd}, 32'd14);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("sat_hold_%0d", i), {28'd0, s_cnt_dd}, 32'd15);
    end
    s_dd = 0;
    tick();
    chk("sat_hold_idle", {28'd0, s_cnt_dd}, 32'd15);
    chk("sat_no_flag",   {31'd0, s_err_dd}, 32'd0);

    // Asynchronous reset in the middle of a cycle, with counts, a flag and WARN live.
    for (int i = 0; i < 5; i++) begin
      cs_mismatch = 1;
      tick();
    end
    cs_mismatch = 0;
    chk_all("pre_arst", 5, 0, 0, 3'b100, 1);
    #3 reset_n = 0;
    #1;
    chk_all("arst", 0, 0, 0, 3'b000, 0);
    chk("arst_small_count", {28'd0, s_cnt_dd}, 32'd0);
    tick();
    chk_all("arst_held", 0, 0, 0, 3'b000, 0);
    reset_n = 1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soft_error_monitor.md
# soft_error_monitor

Counts soft-error events (checksum mismatches, unknown TTC broadcast commands, DDR3 overflows) and compares each count against its IPbus-programmed threshold. It raises the sticky hard-error flags and the per-source counts that the status register block publishes. It sits directly upstream of the status register block: the checksum checker, TTC decoder and DDR3 controller feed it, and the status register block and TTS logic read its outputs.

## Interface
Parameters:
- CNT_W, 32, counter and threshold width

Ports:
- clk  in  1  user interface clock
- reset_n  in  1  asynchronous, active-low reset
- cs_mismatch  in  1  one-cycle pulse per checksum mismatch
- unknown_cmd  in  1  one-cycle pulse per unknown TTC broadcast command
- ddr3_overflow  in  1  one-cycle pulse per DDR3 overflow
- thres_data_corrupt  in  CNT_W  threshold for cs_mismatch; 0 disables the error
- thres_unknown_ttc  in  CNT_W  threshold for unknown_cmd; 0 disables the error
- thres_ddr3_overflow  in  CNT_W  threshold for ddr3_overflow; 0 disables the error
- clear_counts  in  1  IPbus pulse that zeroes all three counters
- clear_errors  in  1  IPbus pulse that clears the sticky error flags
- cs_mismatch_count  out  CNT_W  saturating count of cs_mismatch events
- unknown_cmd_count  out  CNT_W  saturating count of unknown_cmd events
- ddr3_overflow_count  out  CNT_W  saturating count of ddr3_overflow events
- error_data_corrupt  out  1  sticky flag: cs_mismatch count reached its threshold
- error_unknown_ttc  out  1  sticky flag: unknown_cmd count reached its threshold
- error_ddr3_overflow  out  1  sticky flag: ddr3_overflow count reached its threshold
- health  out  2  aggregate state: 0 OK, 1 WARN, 2 ERROR

## Operation
- Three identical channels, each with one event input, one counter, one threshold and one sticky flag.
- Counter:
  - +1 per event pulse.
  - Saturates at 2^CNT_W-1; no wrap.
  - clear_counts sets it to 0. If an event arrives in the same cycle as clear_counts, the counter becomes 1.
- Threshold compare:
  - trip = (thr != 0) && (count >= thr), evaluated on the registered count.
  - A threshold change takes effect on the next compare.
  - Lowering the threshold below the current count trips the flag on the next compare.
- Sticky flag:
  - Set when trip is true.
  - Cleared by clear_errors only.
  - If trip is still true during clear_errors, clear wins for that cycle and the flag re-asserts on the following cycle.
  - clear_counts alone does not clear a flag.
- Health FSM, one instance for all channels:
  - OK -> WARN when any channel with thr != 0 has count >= (thr >> 1), and no flag is set.
  - OK or WARN -> ERROR when any sticky flag is set.
  - WARN -> OK when the warn condition is gone, for example after clear_counts.
  - ERROR -> OK or WARN, whichever applies, on the cycle after all flags clear.
  - Encoding 3 is unreachable; if it occurs, the FSM goes to OK.
- Reset: all counters 0, all flags 0, health OK. Reset acts immediately and asynchronously in any state.

## Timing
- Event pulse in cycle N: count output updates at the edge ending N (visible in N+1).
- Flag asserts in N+2; health moves to ERROR in N+3.
- clear_errors in cycle N: flag low in N+1 and health leaves ERROR in N+2, unless trip persists, in which case the flag is high again in N+2.
- Back-to-back events, one per cycle, are all counted; no event is lost.
- Events are assumed already synchronous to clk; no synchroniser is in this block.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Package soft_error_pkg holds:
  - CNT_W default
  - health encodings HEALTH_OK=2'd0, HEALTH_WARN=2'd1, HEALTH_ERROR=2'd2
- Sub-module soft_err_channel contains the counter, compare register and sticky flag. It is instantiated three times.
- The top level holds only the channel instances and the health FSM.

## Test plan
- Reset release, 10 idle cycles -> all counts 0, all flags 0, health 0.
- thres_data_corrupt=4, four cs_mismatch pulses on consecutive cycles -> count=4 one cycle after the last pulse; error_data_corrupt=1 one cycle later; health=2 one cycle after that.
- thres_unknown_ttc=0, 100 unknown_cmd pulses -> count=100, error_unknown_ttc stays 0; health stays 0.
- Force ddr3_overflow_count to 0xFFFFFFFE, send 3 pulses -> count holds at 0xFFFFFFFF.
- thres_ddr3_overflow=10, 5 pulses -> health=1; then clear_counts -> count=0, health=0.
- Flag set, clear_errors with the count still above threshold -> flag low for one cycle, then high again.
- Flag set, clear_counts followed by clear_errors -> flag low and health returns to 0.
- clear_counts in the same cycle as an event -> count=1.
- Assert reset_n low mid-count -> all outputs 0 asynchronously.
